// File: rtl/turn_input_cond_if.sv
// turn_input_cond_if: tick, raw switches and conditioned request bundle for turn_input_cond.
interface turn_input_cond_if;
    logic       tick;
    logic       l_in;
    logic       r_in;
    logic       l;
    logic       r;
    logic       restart;
    logic [2:0] state_o;
    modport master (output tick, l_in, r_in, input l, r, restart, state_o);
    modport slave  (input tick, l_in, r_in, output l, r, restart, state_o);
endinterface

// File: rtl/turn_input_cond.sv
// turn_input_cond: synchronise, debounce and arbitrate turn switches into l/r requests.
// Optional macro TURN_HAZARD_EN enables the HAZ state (both switches on).
module turn_input_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_TICKS   = 4,
    parameter int GAP_TICKS   = 2
) (
    input logic             clk,
    input logic             rst,
    turn_input_cond_if.slave bus
);
`ifdef TURN_HAZARD_EN
    typedef enum logic [2:0] {IDLE = 3'd0, LEFT = 3'd1, RIGHT = 3'd2, HAZ = 3'd3, GAP = 3'd4} state_t;
`else
    typedef enum logic [2:0] {IDLE = 3'd0, LEFT = 3'd1, RIGHT = 3'd2, GAP = 3'd4} state_t;
`endif
    localparam logic [7:0] DEB_MAX  = 8'(DEB_TICKS - 1);
    localparam logic [7:0] GAP_LOAD = 8'(GAP_TICKS - 1);
    logic [1:0][SYNC_STAGES-1:0] sync;
    logic [1:0]                  s, db, eff;
    logic [1:0][7:0]             cnt;
    logic [7:0]                  gap_cnt, gap_nxt;
    state_t                      state, nxt;
    assign s = {sync[1][SYNC_STAGES-1], sync[0][SYNC_STAGES-1]};
`ifdef TURN_HAZARD_EN
    assign eff = db;
`else
    // Without hazard support both-on is indistinguishable from both-off.
    assign eff = (db == 2'b11) ? 2'b00 : db;
`endif
    function automatic state_t decode(input logic [1:0] v);
        return v == 2'b10 ? LEFT : v == 2'b01 ? RIGHT :
`ifdef TURN_HAZARD_EN
               v == 2'b11 ? HAZ :
`endif
               IDLE;
    endfunction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= '0;
            db   <= '0;
            cnt  <= '0;
        end else begin
            sync[1] <= {sync[1][SYNC_STAGES-2:0], bus.l_in};
            sync[0] <= {sync[0][SYNC_STAGES-2:0], bus.r_in};
            for (int i = 0; i < 2; i++)
                if (bus.tick) begin
                    if (s[i] == db[i]) cnt[i] <= '0;
                    else if (cnt[i] == DEB_MAX) begin
                        db[i]  <= ~db[i];
                        cnt[i] <= '0;
                    end else cnt[i] <= cnt[i] + 8'd1;
                end
        end
    end
    always_comb begin
        nxt     = state;
        gap_nxt = gap_cnt;
        if (bus.tick)
            case (state)
                IDLE:  nxt = decode(eff);
                LEFT:  nxt = eff == 2'b10 ? LEFT  : eff == 2'b00 ? IDLE : GAP;
                RIGHT: nxt = eff == 2'b01 ? RIGHT : eff == 2'b00 ? IDLE : GAP;
`ifdef TURN_HAZARD_EN
                HAZ:   nxt = eff == 2'b11 ? HAZ   : eff == 2'b00 ? IDLE : GAP;
`endif
                GAP: begin
                    nxt     = gap_cnt == 8'd0 ? decode(eff) : GAP;
                    gap_nxt = gap_cnt == 8'd0 ? gap_cnt : gap_cnt - 8'd1;
                end
                default: nxt = IDLE;
            endcase
        if (nxt == GAP && state != GAP) gap_nxt = GAP_LOAD;
    end
    // l/r/restart decode the next state so they change on the same edge as state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            gap_cnt     <= '0;
            bus.l       <= 1'b0;
            bus.r       <= 1'b0;
            bus.restart <= 1'b0;
        end else begin
            state       <= nxt;
            gap_cnt     <= gap_nxt;
`ifdef TURN_HAZARD_EN
            bus.l       <= nxt == LEFT  || nxt == HAZ;
            bus.r       <= nxt == RIGHT || nxt == HAZ;
            bus.restart <= nxt != state && (nxt == LEFT || nxt == RIGHT || nxt == HAZ);
`else
            bus.l       <= nxt == LEFT;
            bus.r       <= nxt == RIGHT;
            bus.restart <= nxt != state && (nxt == LEFT || nxt == RIGHT);
`endif
        end
    end
    assign bus.state_o = state;
endmodule

// File: tb/tb_turn_input_cond.sv
// tb_turn_input_cond: directed-vector bench for turn_input_cond (SYNC=2, DEB=4, GAP=2).
module tb_turn_input_cond;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    turn_input_cond_if bus ();
    turn_input_cond dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic tk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; bus.tick = 1'b1; bus.l_in = 1'b1; bus.r_in = 1'b0;
        tk(3);
        checks++; if (bus.l !== 1'b0) begin errors++; $display("FAIL reset_l got %b want 0", bus.l); end
        checks++; if (bus.r !== 1'b0) begin errors++; $display("FAIL reset_r got %b want 0", bus.r); end
        checks++; if (bus.restart !== 1'b0) begin errors++; $display("FAIL reset_restart got %b want 0", bus.restart); end
        checks++; if (bus.state_o !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus.state_o); end
        rst = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tk(1);
            checks++;
            if (bus.l !== (i >= 7) || bus.restart !== (i == 7))
                begin errors++; $display("FAIL release_latency clk %0d l=%b restart=%b want l=%b restart=%b", i, bus.l, bus.restart, i >= 7, i == 7); end
        end
        bus.l_in = 1'b0;
        tk(10);
        checks++; if (bus.state_o !== 3'd0) begin errors++; $display("FAIL release_idle got %0d want 0", bus.state_o); end
    endtask

    task automatic test_glitch();
        bus.l_in = 1'b1;
        tk(3);
        bus.l_in = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tk(1);
            checks++;
            if (bus.l !== 1'b0 || bus.state_o !== 3'd0)
                begin errors++; $display("FAIL glitch clk %0d l=%b state=%0d want l=0 state=0", i, bus.l, bus.state_o); end
        end
    endtask

    task automatic test_direction();
        logic       el, er, ers;
        logic [2:0] es;
        bus.l_in = 1'b1;
        tk(7);
        checks++; if (bus.l !== 1'b1 || bus.state_o !== 3'd1) begin errors++; $display("FAIL dir_left l=%b state=%0d want l=1 state=1", bus.l, bus.state_o); end
        bus.l_in = 1'b0; bus.r_in = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tk(1);
            el  = i <= 6;
            er  = i >= 9;
            ers = i == 9;
            es  = i <= 6 ? 3'd1 : i <= 8 ? 3'd4 : 3'd2;
            checks++;
            if (bus.l !== el || bus.r !== er || bus.restart !== ers || bus.state_o !== es)
                begin errors++; $display("FAIL dir_change clk %0d l=%b r=%b restart=%b state=%0d want %b %b %b %0d", i, bus.l, bus.r, bus.restart, bus.state_o, el, er, ers, es); end
        end
        bus.r_in = 1'b0;
        tk(10);
    endtask

`ifdef TURN_HAZARD_EN
    task automatic test_hazard();
        logic       el, er, ers;
        logic [2:0] es;
        bus.l_in = 1'b1; bus.r_in = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tk(1);
            checks++;
            if (bus.l !== (i == 7) || bus.r !== (i == 7) || bus.restart !== (i == 7) || bus.state_o !== (i == 7 ? 3'd3 : 3'd0))
                begin errors++; $display("FAIL haz_entry clk %0d l=%b r=%b restart=%b state=%0d", i, bus.l, bus.r, bus.restart, bus.state_o); end
        end
        bus.r_in = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tk(1);
            el  = i <= 6 || i >= 9;
            er  = i <= 6;
            ers = i == 9;
            es  = i <= 6 ? 3'd3 : i <= 8 ? 3'd4 : 3'd1;
            checks++;
            if (bus.l !== el || bus.r !== er || bus.restart !== ers || bus.state_o !== es)
                begin errors++; $display("FAIL haz_exit clk %0d l=%b r=%b restart=%b state=%0d want %b %b %b %0d", i, bus.l, bus.r, bus.restart, bus.state_o, el, er, ers, es); end
        end
        bus.l_in = 1'b0;
        tk(10);
    endtask
`else
    task automatic test_hazard();
        bus.r_in = 1'b1;
        tk(7);
        checks++; if (bus.r !== 1'b1 || bus.state_o !== 3'd2) begin errors++; $display("FAIL nohaz_right r=%b state=%0d want r=1 state=2", bus.r, bus.state_o); end
        bus.l_in = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tk(1);
            checks++;
            if (bus.l !== 1'b0 || bus.r !== (i <= 6) || bus.state_o !== (i <= 6 ? 3'd2 : 3'd0))
                begin errors++; $display("FAIL nohaz_both clk %0d l=%b r=%b state=%0d", i, bus.l, bus.r, bus.state_o); end
        end
        bus.l_in = 1'b0; bus.r_in = 1'b0;
        tk(10);
    endtask
`endif

    task automatic test_tick();
        int         n = 0;
        logic [2:0] ps;
        logic       pl;
        bus.l_in = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            bus.tick = (c % 5 == 0);
            ps = bus.state_o;
            pl = bus.l;
            tk(1);
            if (bus.tick) n++;
            if (!bus.tick) begin
                checks++;
                if (bus.state_o !== ps || bus.l !== pl)
                    begin errors++; $display("FAIL tick_hold clk %0d state=%0d l=%b want state=%0d l=%b", c, bus.state_o, bus.l, ps, pl); end
            end
            checks++;
            if (bus.l !== (n >= 5))
                begin errors++; $display("FAIL tick_gate clk %0d ticks %0d l=%b want %b", c, n, bus.l, n >= 5); end
        end
        bus.tick = 1'b1; bus.l_in = 1'b0;
        tk(10);
    endtask

    task automatic test_reset_mid_gap();
        bus.l_in = 1'b1;
        tk(7);
        bus.l_in = 1'b0; bus.r_in = 1'b1;
        tk(8);
        checks++; if (bus.state_o !== 3'd4) begin errors++; $display("FAIL midgap_state got %0d want 4", bus.state_o); end
        rst = 1'b0;
        #1;
        checks++; if (bus.state_o !== 3'd0 || bus.l !== 1'b0 || bus.r !== 1'b0) begin errors++; $display("FAIL midgap_async state=%0d l=%b r=%b want 0 0 0", bus.state_o, bus.l, bus.r); end
        tk(2);
        rst = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tk(1);
            checks++;
            if (bus.r !== (i >= 7) || bus.restart !== (i == 7) || bus.state_o !== (i >= 7 ? 3'd2 : 3'd0))
                begin errors++; $display("FAIL midgap_restart clk %0d r=%b restart=%b state=%0d", i, bus.r, bus.restart, bus.state_o); end
        end
        bus.r_in = 1'b0;
        tk(10);
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_direction();
        test_hazard();
        test_tick();
        test_reset_mid_gap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
